gpr_read_file: RTL and testbench
================================

Name: gpr_read_file

Overview:
- General-purpose register bank for the convolution processor datapath: 16 x 32-bit storage written by the writeback stage and read through two independent read ports feeding ALU operands A and B.
- Registered reads (1-cycle latency) with same-cycle write-to-read bypass, so the execute stage never observes stale operands.
- Replaces discrete R32 instances on the operand side; the writer side keeps the CE-style write enable.

Parameters:
- DW, 32, data width of each register
- AW, 4, address width; depth = 2**AW
- ZERO_R0, 0, when 1, register 0 reads as 0 and ignores writes

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- CLR  in  1  synchronous active-high reset
- WE  in  1  write enable (CE of write port)
- WA  in  AW  write address
- WD  in  DW  write data
- REA  in  1  read request, port A
- RAA  in  AW  read address, port A
- REB  in  1  read request, port B
- RAB  in  AW  read address, port B
- QA  out  DW  read data, port A (registered)
- QB  out  DW  read data, port B (registered)
- VA  out  1  QA valid, high one cycle per accepted REA
- VB  out  1  QB valid, high one cycle per accepted REB

Behaviour:
- Reset: CLR sampled high at a rising edge clears all 2**AW registers to 0, QA=QB=0, VA=VB=0. CLR overrides WE/REA/REB in the same cycle; the write is dropped and the reads return nothing.
- Write: at an edge with WE=1 and CLR=0, mem[WA] <= WD. When ZERO_R0=1 and WA=0, the write is ignored.
- Read latency: REA=1 at edge N gives QA = data of mem[RAA] and VA=1 after edge N, held until edge N+1. The same rule applies to port B.
- Read hold: with REA=0 at an edge, VA goes to 0 and QA holds its previous value (no update, no clear). The same rule applies to port B.
- Bypass: at the same edge, WE=1, REA=1 and RAA==WA (write not suppressed by ZERO_R0) gives QA=WD (new data, write-first). Port B is identical.
- Both ports may read the same address in the same cycle; each receives identical data.
- ZERO_R0=1: a read of address 0 returns 0 regardless of any write or bypass.
- Back-to-back reads are allowed every cycle. There is no stall or backpressure, and each request produces exactly one valid pulse.
- Reset mid-operation: a read issued in the cycle CLR is high produces no VA/VB pulse. Reads accepted in the cycle before CLR still present their data for the one cycle after the edge, then CLR clears QA/QB on the following edge only if CLR is still held.
- There are no combinational paths from inputs to outputs; QA/QB/VA/VB are flops.
- Storage is a flop array, 16x32, with no RAM macro. Addresses outside the depth cannot occur because the width equals the depth.

Test Plan:
- Reset clear: write 0x12345678 to r3, assert CLR for 1 cycle, then read r3 -> QA=0x00000000, VA=1 exactly one cycle after REA.
- Basic write/read: write r1=0xABCDEF01 and r2=0x87654321 on consecutive cycles, then read A=r1, B=r2 in the same cycle -> next cycle QA=0xABCDEF01, QB=0x87654321, VA=VB=1.
- Bypass: r5 holds 0x11111111. In the same cycle WE=1, WA=5, WD=0x22222222, REA=1, RAA=5 -> QA=0x22222222. A read of r5 on the next cycle also gives 0x22222222.
- Hold/valid: read r1 (QA=0xABCDEF01), then REA=0 for 3 cycles -> VA=0 and QA stays 0xABCDEF01 for all 3 cycles.
- ZERO_R0=1 instance: write r0=0xDEADBEEF with a simultaneous read of r0 on both ports -> QA=QB=0, and a later read of r0 also gives 0.
- CLR precedence: in one cycle WE=1, WA=7, WD=0xCAFEF00D, REA=1, CLR=1 -> VA=0 next cycle. A later read of r7 gives 0.

Source files
------------

// File: rtl/gpr_read_file_if.sv
// Operand-side register file bus: one write port plus two read ports.
// Purely a signal bundle; timing is defined by the register file itself.
// No flow control: every request is accepted on the edge it is presented.
interface gpr_read_file_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    // Write port (writeback stage)
    logic          WE;
    logic [AW-1:0] WA;
    logic [DW-1:0] WD;
    // Read port A (ALU operand A)
    logic          REA;
    logic [AW-1:0] RAA;
    logic [DW-1:0] QA;
    logic          VA;
    // Read port B (ALU operand B)
    logic          REB;
    logic [AW-1:0] RAB;
    logic [DW-1:0] QB;
    logic          VB;

    // Pipeline side: issues writes and read requests, consumes read data
    modport master (
        output WE, WA, WD, REA, RAA, REB, RAB,
        input  QA, QB, VA, VB
    );

    // Register file side
    modport slave (
        input  WE, WA, WD, REA, RAA, REB, RAB,
        output QA, QB, VA, VB
    );
endinterface

// File: rtl/gpr_read_file.sv
// General-purpose register bank, 2**AW x DW flops, one write port and two read ports.
// Latency: read data and valid appear one cycle after the request, write-first bypass.
// Backpressure: none; reads and writes are accepted every cycle, one valid per read.
module gpr_read_file #(
    parameter int DW      = 32,
    parameter int AW      = 4,
    parameter int ZERO_R0 = 0
) (
    input  logic            CLK,
    input  logic            CLR,
    gpr_read_file_if.slave  bus
);

    localparam int DEPTH = 1 << AW;

    // Register storage, plain flops so every entry can be cleared in one edge
    logic [DW-1:0] r_mem [DEPTH];

    // Output registers for both read ports
    logic [DW-1:0] r_qa;
    logic [DW-1:0] r_qb;
    logic          r_va;
    logic          r_vb;

    // Write qualification and next read data
    logic          w_zero_en;
    logic          w_wr_en;
    logic          w_byp_a;
    logic          w_byp_b;
    logic [DW-1:0] w_rd_a;
    logic [DW-1:0] w_rd_b;

    assign w_zero_en = (ZERO_R0 != 0);

    // A write to r0 is dropped entirely when r0 is hardwired to zero, which
    // also keeps it from being forwarded through the bypass below.
    assign w_wr_en = bus.WE && !(w_zero_en && (bus.WA == '0));

    assign w_byp_a = w_wr_en && (bus.WA == bus.RAA);
    assign w_byp_b = w_wr_en && (bus.WA == bus.RAB);

    // Select port A read data: forced zero for r0, then write-first bypass, then storage
    always_comb begin
        w_rd_a = r_mem[bus.RAA];
        if (w_zero_en && (bus.RAA == '0)) begin
            w_rd_a = '0;
        end else if (w_byp_a) begin
            w_rd_a = bus.WD;
        end
    end

    // Select port B read data with the same priority as port A
    always_comb begin
        w_rd_b = r_mem[bus.RAB];
        if (w_zero_en && (bus.RAB == '0)) begin
            w_rd_b = '0;
        end else if (w_byp_b) begin
            w_rd_b = bus.WD;
        end
    end

    // Storage update: clear wins over a write presented in the same cycle
    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[bus.WA] <= bus.WD;
        end
    end

    // Port A output register: load on request, otherwise hold data and drop valid
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_qa <= '0;
            r_va <= 1'b0;
        end else begin
            r_va <= bus.REA;
            if (bus.REA) begin
                r_qa <= w_rd_a;
            end
        end
    end

    // Port B output register: same behaviour as port A
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_qb <= '0;
            r_vb <= 1'b0;
        end else begin
            r_vb <= bus.REB;
            if (bus.REB) begin
                r_qb <= w_rd_b;
            end
        end
    end

    assign bus.QA = r_qa;
    assign bus.QB = r_qb;
    assign bus.VA = r_va;
    assign bus.VB = r_vb;

endmodule

// File: tb/tb_gpr_read_file.sv
// Bench for gpr_read_file: one plain instance and one with r0 hardwired to zero,
// both driven by identical stimulus and compared every cycle against a model.
module tb_gpr_read_file;

    logic clk;
    logic clr;

    // Shared stimulus for both instances
    logic        d_we;
    logic [3:0]  d_wa;
    logic [31:0] d_wd;
    logic        d_rea;
    logic [3:0]  d_raa;
    logic        d_reb;
    logic [3:0]  d_rab;

    gpr_read_file_if #(.DW(32), .AW(4)) bus_p ();
    gpr_read_file_if #(.DW(32), .AW(4)) bus_z ();

    assign bus_p.WE  = d_we;   assign bus_z.WE  = d_we;
    assign bus_p.WA  = d_wa;   assign bus_z.WA  = d_wa;
    assign bus_p.WD  = d_wd;   assign bus_z.WD  = d_wd;
    assign bus_p.REA = d_rea;  assign bus_z.REA = d_rea;
    assign bus_p.RAA = d_raa;  assign bus_z.RAA = d_raa;
    assign bus_p.REB = d_reb;  assign bus_z.REB = d_reb;
    assign bus_p.RAB = d_rab;  assign bus_z.RAB = d_rab;

    gpr_read_file #(.DW(32), .AW(4), .ZERO_R0(0)) dut_p (
        .CLK (clk),
        .CLR (clr),
        .bus (bus_p)
    );

    gpr_read_file #(.DW(32), .AW(4), .ZERO_R0(1)) dut_z (
        .CLK (clk),
        .CLR (clr),
        .bus (bus_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model, index 0 = plain instance, 1 = r0-is-zero instance
    logic [31:0] m_mem [2][16];
    logic [31:0] e_qa [2];
    logic [31:0] e_qb [2];
    logic        e_va [2];
    logic        e_vb [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: on each edge apply clear, else write first, then serve reads from the updated array
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                for (int i = 0; i < 16; i++) m_mem[k][i] = 32'h0;
                e_qa[k] = 32'h0;
                e_qb[k] = 32'h0;
                e_va[k] = 1'b0;
                e_vb[k] = 1'b0;
            end else begin
                if (d_we && !(k == 1 && d_wa == 4'd0)) m_mem[k][d_wa] = d_wd;
                e_va[k] = d_rea;
                e_vb[k] = d_reb;
                if (d_rea) e_qa[k] = m_mem[k][d_raa];
                if (d_reb) e_qb[k] = m_mem[k][d_rab];
            end
        end
    end

    // Compare all outputs of both instances against the model each cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("p_QA", bus_p.QA, e_qa[0]);
            check("p_QB", bus_p.QB, e_qb[0]);
            check("p_VA", {31'h0, bus_p.VA}, {31'h0, e_va[0]});
            check("p_VB", {31'h0, bus_p.VB}, {31'h0, e_vb[0]});
            check("z_QA", bus_z.QA, e_qa[1]);
            check("z_QB", bus_z.QB, e_qb[1]);
            check("z_VA", {31'h0, bus_z.VA}, {31'h0, e_va[1]});
            check("z_VB", {31'h0, bus_z.VB}, {31'h0, e_vb[1]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr   = 1'b0;
        d_we  = 1'b0;
        d_wa  = 4'd0;
        d_wd  = 32'h0;
        d_rea = 1'b0;
        d_raa = 4'd0;
        d_reb = 1'b0;
        d_rab = 4'd0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        idle();
        d_we = 1'b1;
        d_wa = a;
        d_wd = d;
        cyc();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) m_mem[k][i] = 32'h0;
            e_qa[k] = 32'h0; e_qb[k] = 32'h0; e_va[k] = 1'b0; e_vb[k] = 1'b0;
        end
        idle();
        clr = 1'b1;
        cyc();
        chk_en = 1'b1;
        check("rst_QA", bus_p.QA, 32'h0);
        check("rst_VA", {31'h0, bus_p.VA}, 32'h0);

        // Reset clears stored data
        wr(4'd3, 32'h12345678);
        idle(); clr = 1'b1; cyc();
        idle(); d_rea = 1'b1; d_raa = 4'd3; cyc();
        check("clr_r3_QA", bus_p.QA, 32'h0);
        check("clr_r3_VA", {31'h0, bus_p.VA}, 32'h1);
        idle(); cyc();
        check("clr_r3_VA_drop", {31'h0, bus_p.VA}, 32'h0);

        // Basic write then dual read
        wr(4'd1, 32'hABCDEF01);
        wr(4'd2, 32'h87654321);
        idle(); d_rea = 1'b1; d_raa = 4'd1; d_reb = 1'b1; d_rab = 4'd2; cyc();
        check("basic_QA", bus_p.QA, 32'hABCDEF01);
        check("basic_QB", bus_p.QB, 32'h87654321);
        check("basic_VA", {31'h0, bus_p.VA}, 32'h1);
        check("basic_VB", {31'h0, bus_p.VB}, 32'h1);

        // Hold: no requests, data stays, valid low
        for (int n = 0; n < 3; n++) begin
            idle(); cyc();
            check("hold_QA", bus_p.QA, 32'hABCDEF01);
            check("hold_VA", {31'h0, bus_p.VA}, 32'h0);
        end

        // Same-cycle write-to-read bypass
        wr(4'd5, 32'h11111111);
        idle(); d_we = 1'b1; d_wa = 4'd5; d_wd = 32'h22222222; d_rea = 1'b1; d_raa = 4'd5; cyc();
        check("byp_QA", bus_p.QA, 32'h22222222);
        idle(); d_rea = 1'b1; d_raa = 4'd5; cyc();
        check("byp_after_QA", bus_p.QA, 32'h22222222);

        // r0 write with simultaneous reads on both ports
        idle(); d_we = 1'b1; d_wa = 4'd0; d_wd = 32'hDEADBEEF;
        d_rea = 1'b1; d_raa = 4'd0; d_reb = 1'b1; d_rab = 4'd0; cyc();
        check("z_r0_QA", bus_z.QA, 32'h0);
        check("z_r0_QB", bus_z.QB, 32'h0);
        check("p_r0_QA", bus_p.QA, 32'hDEADBEEF);
        idle(); d_rea = 1'b1; d_raa = 4'd0; cyc();
        check("z_r0_later", bus_z.QA, 32'h0);
        check("p_r0_later", bus_p.QA, 32'hDEADBEEF);

        // Clear beats a same-cycle write and read
        idle(); clr = 1'b1; d_we = 1'b1; d_wa = 4'd7; d_wd = 32'hCAFEF00D; d_rea = 1'b1; d_raa = 4'd7; cyc();
        check("clrprec_VA", {31'h0, bus_p.VA}, 32'h0);
        idle(); d_rea = 1'b1; d_raa = 4'd7; cyc();
        check("clrprec_r7", bus_p.QA, 32'h0);
        check("clrprec_r7_VA", {31'h0, bus_p.VA}, 32'h1);

        // Randomized traffic, biased toward bypass hits and address 0
        for (int n = 0; n < 800; n++) begin
            clr   = ($urandom_range(0, 59) == 0);
            d_we  = 1'($urandom_range(0, 1));
            d_wa  = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            d_wd  = $urandom;
            d_rea = ($urandom_range(0, 3) != 0);
            d_raa = ($urandom_range(0, 2) == 0) ? d_wa : 4'($urandom_range(0, 15));
            d_reb = ($urandom_range(0, 3) != 0);
            d_rab = ($urandom_range(0, 2) == 0) ? d_wa : 4'($urandom_range(0, 15));
            cyc();
        end

        idle();
        cyc();
        cyc();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
